// File: rtl/icache.sv
// Direct-mapped instruction cache with 4-word lines and a single outstanding refill.
// Hits are answered combinationally in IDLE; misses walk REQ -> FILL -> UPDATE.
module icache #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ADR_SI,
  input  logic        ADR_VALID_SI,
  input  logic        IC_FLUSH,
  output logic [31:0] IC_INST_SI,
  output logic        IC_STALL_SI,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADR,
  input  logic        MEM_GNT,
  input  logic [31:0] MEM_DATA,
  input  logic        MEM_DATA_VALID
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             flush_pending_q, flush_pending_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
  logic             valid_q [NUM_LINES];

  logic [TAG_W-1:0] tag_mem  [NUM_LINES];
  logic [31:0]      data_mem [NUM_LINES*LINE_WORDS];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [1:0]       lk_off;
  logic             lk_hit;
  logic             fill_we;
  logic             upd;
  logic             unused_adr_bits;

  assign lk_off = ADR_SI[3:2];
  assign lk_idx = ADR_SI[4+IDX_W-1:4];
  assign lk_tag = ADR_SI[31:4+IDX_W];
  assign lk_hit = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign unused_adr_bits = ^ADR_SI[1:0];

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    flush_pending_d = flush_pending_q;
    miss_tag_d      = miss_tag_q;
    miss_idx_d      = miss_idx_q;
    IC_INST_SI      = NOP;
    IC_STALL_SI     = 1'b0;
    fill_we         = 1'b0;
    upd             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ADR_VALID_SI) begin
          if (lk_hit) begin
            IC_INST_SI = data_mem[{lk_idx, lk_off}];
          end else begin
            IC_STALL_SI = 1'b1;
            miss_tag_d  = lk_tag;
            miss_idx_d  = lk_idx;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        IC_STALL_SI = 1'b1;
        if (MEM_GNT) begin
          cnt_d   = 2'd0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        IC_STALL_SI = 1'b1;
        if (MEM_DATA_VALID) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_UPDATE;
        end
      end
      default: begin
        IC_STALL_SI     = 1'b1;
        upd             = 1'b1;
        flush_pending_d = 1'b0;
        state_d         = S_IDLE;
      end
    endcase
    // A flush during UPDATE needs no pending flag: it clears the line being validated directly.
    if (IC_FLUSH && (state_q == S_REQ || state_q == S_FILL)) flush_pending_d = 1'b1;
    if (!reset_n) begin
      IC_STALL_SI = 1'b0;
      IC_INST_SI  = NOP;
    end
  end

  assign MEM_REQ = (state_q == S_REQ);
  assign MEM_ADR = MEM_REQ ? {miss_tag_q, miss_idx_q, 4'b0000} : 32'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= 2'd0;
      flush_pending_q <= 1'b0;
      miss_tag_q      <= '0;
      miss_idx_q      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      miss_tag_q      <= miss_tag_d;
      miss_idx_q      <= miss_idx_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_q[gi] <= 1'b0;
        end else if (IC_FLUSH) begin
          valid_q[gi] <= 1'b0;
        end else if (upd && !flush_pending_q && (miss_idx_q == IDX_W'(gi))) begin
          valid_q[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and data storage carry no reset; validity alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_we) data_mem[{miss_idx_q, cnt_q}] <= MEM_DATA;
    if (upd)     tag_mem[miss_idx_q]           <= miss_tag_q;
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written refill corner cases,
// then random fetches checked against a line-address model of the cache contents.
module tb_icache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ADR_SI = 32'h0;
  logic        ADR_VALID_SI = 1'b0;
  logic        IC_FLUSH = 1'b0;
  logic [31:0] IC_INST_SI;
  logic        IC_STALL_SI;
  logic        MEM_REQ;
  logic [31:0] MEM_ADR;
  logic        MEM_GNT = 1'b0;
  logic [31:0] MEM_DATA = 32'h0;
  logic        MEM_DATA_VALID = 1'b0;

  int checks = 0;
  int errors = 0;
  bit [31:0] cached [int];

  icache #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .ADR_SI(ADR_SI), .ADR_VALID_SI(ADR_VALID_SI),
    .IC_FLUSH(IC_FLUSH), .IC_INST_SI(IC_INST_SI), .IC_STALL_SI(IC_STALL_SI),
    .MEM_REQ(MEM_REQ), .MEM_ADR(MEM_ADR), .MEM_GNT(MEM_GNT), .MEM_DATA(MEM_DATA),
    .MEM_DATA_VALID(MEM_DATA_VALID)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] line;
    logic [31:0] inst;
    int          gnt_dly;
    int          max_gap;
  } vec_t;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE ^ a[31:16], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serves one refill starting in the first REQ cycle; returns in the IDLE cycle after UPDATE.
  task automatic refill(input logic [31:0] line, input logic [31:0] orig, input int gnt_dly,
                        input int max_gap, input int flush_at, output bit flushed);
    flushed = 1'b0;
    for (int c = 0; c <= gnt_dly; c++) begin
      MEM_GNT        = (c == gnt_dly);
      MEM_DATA_VALID = 1'($urandom_range(0, 1));
      MEM_DATA       = $urandom;
      ADR_SI         = $urandom;
      ADR_VALID_SI   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("req_mem_req", 32'(MEM_REQ), 32'd1);
      chk("req_mem_adr", MEM_ADR, line);
      chk("req_stall", 32'(IC_STALL_SI), 32'd1);
      chk("req_inst", IC_INST_SI, NOP);
      tick();
    end
    MEM_GNT = 1'b0;
    for (int w = 0; w < 4; w++) begin
      int gap = int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        MEM_DATA_VALID = 1'b0;
        MEM_DATA       = $urandom;
        @(negedge clk);
        chk("fill_stall", 32'(IC_STALL_SI), 32'd1);
        chk("fill_mem_req", 32'(MEM_REQ), 32'd0);
        chk("fill_mem_adr", MEM_ADR, 32'h0);
        tick();
      end
      MEM_DATA_VALID = 1'b1;
      MEM_DATA       = memfn(line + 32'(4 * w));
      IC_FLUSH       = (flush_at == w);
      if (flush_at == w) flushed = 1'b1;
      if (w == 3) begin
        ADR_SI       = orig;
        ADR_VALID_SI = 1'b1;
      end
      @(negedge clk);
      chk("fill_inst", IC_INST_SI, NOP);
      tick();
      IC_FLUSH = 1'b0;
    end
    MEM_DATA_VALID = 1'b0;
    IC_FLUSH       = (flush_at == 4);
    if (flush_at == 4) flushed = 1'b1;
    @(negedge clk);
    chk("update_stall", 32'(IC_STALL_SI), 32'd1);
    chk("update_inst", IC_INST_SI, NOP);
    tick();
    IC_FLUSH = 1'b0;
  endtask

  // Random-phase fetch: expectations come from the cached-line model only.
  task automatic fetch(input logic [31:0] addr, input bit flush_now, input int flush_at,
                       input int gnt_dly, input int max_gap);
    bit          done = 1'b0;
    bit          hit;
    bit          fl;
    int          att_used = 0;
    logic [31:0] line = {addr[31:4], 4'b0000};
    int          idx = int'(addr[9:4]);
    ADR_SI       = addr;
    ADR_VALID_SI = 1'b1;
    IC_FLUSH     = flush_now;
    for (int att = 0; att < 3 && !done; att++) begin
      att_used = att + 1;
      hit = cached.exists(idx) && (cached[idx] == line);
      @(negedge clk);
      chk("rnd_stall", 32'(IC_STALL_SI), 32'(!hit));
      if (hit) begin
        chk("rnd_hit_inst", IC_INST_SI, memfn({addr[31:2], 2'b00}));
        chk("rnd_hit_noreq", 32'(MEM_REQ), 32'd0);
        done = 1'b1;
      end
      if (IC_FLUSH) cached.delete();
      tick();
      IC_FLUSH = 1'b0;
      if (!hit) begin
        refill(line, addr, gnt_dly, max_gap, (att == 0) ? flush_at : -1, fl);
        if (fl) cached.delete();
        else cached[idx] = line;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rnd_fetch_bound: addr %h not served after %0d attempts", addr, att_used);
    end
    ADR_VALID_SI = 1'b0;
    $display("fetch addr=%h attempts=%0d flush_idle=%0d flush_at=%0d", addr, att_used, flush_now, flush_at);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    ADR_VALID_SI = 1'b1;
    #1;
    chk("rst_stall", 32'(IC_STALL_SI), 32'd0);
    chk("rst_inst", IC_INST_SI, NOP);
    chk("rst_mem_req", 32'(MEM_REQ), 32'd0);
    chk("rst_mem_adr", MEM_ADR, 32'h0);
    tick();
    tick();
    ADR_VALID_SI = 1'b0;
    reset_n      = 1'b1;
    cached.delete();
  endtask

  vec_t vecs [8];

  initial begin
    bit fl;
    vecs[0] = '{32'h0000_1004, 1'b1, 32'h0000_1000, 32'hD0DA_1004, 0, 0};
    vecs[1] = '{32'h0000_1008, 1'b0, 32'h0,         32'hD0D6_1008, 0, 0};
    vecs[2] = '{32'h0000_100C, 1'b0, 32'h0,         32'hD0D2_100C, 0, 0};
    vecs[3] = '{32'h0000_1400, 1'b1, 32'h0000_1400, 32'hD4DE_1400, 5, 3};
    vecs[4] = '{32'h0000_1000, 1'b1, 32'h0000_1000, 32'hD0DE_1000, 2, 2};
    vecs[5] = '{32'h0000_1404, 1'b1, 32'h0000_1400, 32'hD4DA_1404, 0, 1};
    vecs[6] = '{32'h0000_2010, 1'b1, 32'h0000_2010, 32'hE0CE_2010, 1, 0};
    vecs[7] = '{32'h0000_2014, 1'b0, 32'h0,         32'hE0CA_2014, 0, 0};

    #2;
    do_reset();
    tick();
    @(negedge clk);
    chk("idle_stall", 32'(IC_STALL_SI), 32'd0);
    chk("idle_inst", IC_INST_SI, NOP);
    chk("idle_mem_adr", MEM_ADR, 32'h0);
    tick();

    for (int i = 0; i < 8; i++) begin
      ADR_SI       = vecs[i].addr;
      ADR_VALID_SI = 1'b1;
      @(negedge clk);
      chk("vec_stall", 32'(IC_STALL_SI), 32'(vecs[i].miss));
      if (!vecs[i].miss) begin
        chk("vec_hit_inst", IC_INST_SI, vecs[i].inst);
        chk("vec_hit_noreq", 32'(MEM_REQ), 32'd0);
      end
      tick();
      if (vecs[i].miss) begin
        refill(vecs[i].line, vecs[i].addr, vecs[i].gnt_dly, vecs[i].max_gap, -1, fl);
        @(negedge clk);
        chk("vec_post_stall", 32'(IC_STALL_SI), 32'd0);
        chk("vec_post_inst", IC_INST_SI, vecs[i].inst);
        tick();
      end
      $display("vector %0d addr=%h miss=%0d", i, vecs[i].addr, vecs[i].miss);
    end

    // Flush pulsed mid-fill: line completes but stays invalid; older lines are gone too.
    ADR_SI = 32'h0000_3020;
    ADR_VALID_SI = 1'b1;
    @(negedge clk);
    chk("flushfill_miss", 32'(IC_STALL_SI), 32'd1);
    tick();
    refill(32'h0000_3020, 32'h0000_3020, 1, 1, 2, fl);
    @(negedge clk);
    chk("flushfill_refetch_miss", 32'(IC_STALL_SI), 32'd1);
    tick();
    refill(32'h0000_3020, 32'h0000_3020, 0, 0, -1, fl);
    @(negedge clk);
    chk("flushfill_second_stall", 32'(IC_STALL_SI), 32'd0);
    chk("flushfill_second_inst", IC_INST_SI, 32'hF0FE_3020);
    tick();
    ADR_SI = 32'h0000_2014;
    @(negedge clk);
    chk("flushfill_old_miss", 32'(IC_STALL_SI), 32'd1);
    tick();
    refill(32'h0000_2010, 32'h0000_2014, 0, 0, 4, fl);
    @(negedge clk);
    chk("flush_update_miss", 32'(IC_STALL_SI), 32'd1);
    tick();
    refill(32'h0000_2010, 32'h0000_2014, 0, 0, -1, fl);
    @(negedge clk);
    chk("flush_update_inst", IC_INST_SI, 32'hE0CA_2014);
    tick();
    $display("sequence flush-during-fill done");

    // Reset during REQ, then reset after two data beats.
    ADR_SI = 32'h0000_1004;
    @(negedge clk);
    chk("rstreq_miss", 32'(IC_STALL_SI), 32'd1);
    tick();
    @(negedge clk);
    chk("rstreq_req", 32'(MEM_REQ), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstreq_req_drop", 32'(MEM_REQ), 32'd0);
    chk("rstreq_adr_drop", MEM_ADR, 32'h0);
    chk("rstreq_stall", 32'(IC_STALL_SI), 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstreq_refetch_miss", 32'(IC_STALL_SI), 32'd1);
    tick();
    MEM_GNT = 1'b1;
    @(negedge clk);
    chk("rstfill_req", MEM_ADR, 32'h0000_1000);
    tick();
    MEM_GNT = 1'b0;
    for (int w = 0; w < 2; w++) begin
      MEM_DATA_VALID = 1'b1;
      MEM_DATA = memfn(32'h0000_1000 + 32'(4 * w));
      tick();
    end
    MEM_DATA_VALID = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstfill_stall", 32'(IC_STALL_SI), 32'd0);
    chk("rstfill_inst", IC_INST_SI, NOP);
    chk("rstfill_mem_req", 32'(MEM_REQ), 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstfill_refetch_miss", 32'(IC_STALL_SI), 32'd1);
    tick();
    refill(32'h0000_1000, 32'h0000_1004, 0, 1, -1, fl);
    @(negedge clk);
    chk("rstfill_refill_inst", IC_INST_SI, 32'hD0DA_1004);
    tick();
    $display("sequence reset-mid-refill done");

    do_reset();
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      int          fa;
      if ($urandom_range(0, 9) == 0) begin
        ADR_VALID_SI = 1'b0;
        ADR_SI = $urandom;
        @(negedge clk);
        chk("rnd_idle_stall", 32'(IC_STALL_SI), 32'd0);
        chk("rnd_idle_inst", IC_INST_SI, NOP);
        chk("rnd_idle_mem_adr", MEM_ADR, 32'h0);
        tick();
      end
      a = (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 2)) << 10) |
          (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2) |
          32'($urandom_range(0, 3));
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      fetch(a, ($urandom_range(0, 14) == 0), fa, int'($urandom_range(0, 5)), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
